// File: rtl/rf_wport_arbiter_pkg.sv
// Shared types and constants for the regfile write-port arbiter.
//   XLEN        : regfile data width
//   REG_IDX_W   : register index width
//   REG_X0      : hardwired-zero register index
//   arb_state_e : arbitration FSM states
//   rf_wr_t     : one regfile write (index + data)
package rf_wport_arbiter_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;

  localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

  typedef enum logic [0:0] {
    ARB_PRIO0  = 1'b0,
    ARB_FORCE1 = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic [XLEN-1:0]      data;
  } rf_wr_t;

endpackage

// File: rtl/rf_wport_arbiter_if.sv
// Bundle of the two writeback request channels and the regfile write port.
//   s0_*  : main pipeline writeback request (valid/ready/idx/data)
//   s1_*  : multi-cycle unit writeback request (valid/ready/idx/data)
//   rd_*  : registered regfile write enable/index/data
// Modports: slave = arbiter side, master = requesters + regfile side.
interface rf_wport_arbiter_if;
  import rf_wport_arbiter_pkg::*;

  logic                 s0_valid_i;
  logic                 s0_ready_o;
  logic [REG_IDX_W-1:0] s0_idx_i;
  logic [XLEN-1:0]      s0_data_i;

  logic                 s1_valid_i;
  logic                 s1_ready_o;
  logic [REG_IDX_W-1:0] s1_idx_i;
  logic [XLEN-1:0]      s1_data_i;

  logic                 rd_wen_o;
  logic [REG_IDX_W-1:0] rd_idx_o;
  logic [XLEN-1:0]      rd_wdata_o;

  modport slave (
    input  s0_valid_i, s0_idx_i, s0_data_i,
    input  s1_valid_i, s1_idx_i, s1_data_i,
    output s0_ready_o, s1_ready_o,
    output rd_wen_o, rd_idx_o, rd_wdata_o
  );

  modport master (
    output s0_valid_i, s0_idx_i, s0_data_i,
    output s1_valid_i, s1_idx_i, s1_data_i,
    input  s0_ready_o, s1_ready_o,
    input  rd_wen_o, rd_idx_o, rd_wdata_o
  );

endinterface

// File: rtl/rf_arb_grant.sv
// Combinational grant select: picks at most one source from FSM state and valids.
//   state_i    : current arbitration state
//   s0_valid_i : source 0 request
//   s1_valid_i : source 1 request
//   gnt0_o     : source 0 granted
//   gnt1_o     : source 1 granted
module rf_arb_grant
  import rf_wport_arbiter_pkg::*;
(
  input  arb_state_e state_i,
  input  logic       s0_valid_i,
  input  logic       s1_valid_i,
  output logic       gnt0_o,
  output logic       gnt1_o
);

  // Priority flips to source 1 only while the starvation guard is active.
  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    case (state_i)
      ARB_FORCE1: begin
        gnt1_o = s1_valid_i;
        gnt0_o = s0_valid_i & ~s1_valid_i;
      end
      default: begin
        gnt0_o = s0_valid_i;
        gnt1_o = s1_valid_i & ~s0_valid_i;
      end
    endcase
  end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the single regfile write port between the pipeline WB (source 0) and a
// multi-cycle unit (source 1). Source 0 has fixed priority; source 1 is forced
// through after STARVE_MAX blocked cycles. Write port outputs are registered.
//   clk, reset     : clock, synchronous active-high reset
//   bus            : request channels + regfile write port (slave modport)
//   conflict_cnt_o : cycles with both sources requesting (only with RF_ARB_STAT_EN)
// Optional feature macro: RF_ARB_STAT_EN.
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                clk,
  input  logic                reset,
  rf_wport_arbiter_if.slave   bus
`ifdef RF_ARB_STAT_EN
  ,
  output logic [31:0]         conflict_cnt_o
`endif
);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             wen_q, wen_d;
  rf_wr_t           wr_q, wr_d, wr_sel;
  logic             gnt0_raw, gnt1_raw;
  logic             gnt0, gnt1;

  rf_arb_grant u_grant (
    .state_i    (state_q),
    .s0_valid_i (bus.s0_valid_i),
    .s1_valid_i (bus.s1_valid_i),
    .gnt0_o     (gnt0_raw),
    .gnt1_o     (gnt1_raw)
  );

  // Grants, starvation counter, next state and next write-port value.
  always_comb begin
    gnt0 = gnt0_raw & ~reset;
    gnt1 = gnt1_raw & ~reset;

    wr_sel.idx  = gnt1 ? bus.s1_idx_i  : bus.s0_idx_i;
    wr_sel.data = gnt1 ? bus.s1_data_i : bus.s0_data_i;

    // x0 writes are accepted but never reach the regfile; idx/data hold.
    wen_d = (gnt0 | gnt1) && (wr_sel.idx != REG_X0);
    wr_d  = wen_d ? wr_sel : wr_q;

    wcnt_d = (bus.s1_valid_i && !gnt1) ? wcnt_q + CNT_W'(1) : '0;

    state_d = state_q;
    case (state_q)
      ARB_PRIO0: begin
        if (bus.s1_valid_i && !gnt1 && (wcnt_q == CNT_W'(STARVE_MAX - 1)))
          state_d = ARB_FORCE1;
      end
      ARB_FORCE1: begin
        if (gnt1 || !bus.s1_valid_i)
          state_d = ARB_PRIO0;
      end
      default: state_d = ARB_PRIO0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_PRIO0;
      wcnt_q  <= '0;
      wen_q   <= 1'b0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      wen_q   <= wen_d;
      wr_q    <= wr_d;
    end
  end

  assign bus.s0_ready_o = gnt0;
  assign bus.s1_ready_o = gnt1;
  assign bus.rd_wen_o   = wen_q;
  assign bus.rd_idx_o   = wr_q.idx;
  assign bus.rd_wdata_o = wr_q.data;

`ifdef RF_ARB_STAT_EN
  logic [31:0] conflict_q, conflict_d;

  // Wraps naturally at 2^32.
  always_comb begin
    conflict_d = conflict_q;
    if (bus.s0_valid_i && bus.s1_valid_i)
      conflict_d = conflict_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) conflict_q <= '0;
    else       conflict_q <= conflict_d;
  end

  assign conflict_cnt_o = conflict_q;
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Scoreboard bench for rf_wport_arbiter: the driver predicts grants from the
// arbitration rules and queues expected regfile writes; a monitor pops and
// compares whenever the write port is enabled.
module tb_rf_wport_arbiter;
  import rf_wport_arbiter_pkg::*;

  localparam int unsigned STARVE_MAX = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rf_wport_arbiter_if bus ();

`ifdef RF_ARB_STAT_EN
  logic [31:0] conflict_cnt;
  int unsigned conflict_model = 0;
`endif

  rf_wport_arbiter #(.STARVE_MAX(STARVE_MAX), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef RF_ARB_STAT_EN
    ,
    .conflict_cnt_o (conflict_cnt)
`endif
  );

  int          checks   = 0;
  int          failures = 0;
  rf_wr_t      exp_q[$];
  logic [31:0] shadow_rf [32];
  int unsigned wait1    = 0;   // consecutive cycles src1 has been refused
  logic        mon_en   = 1'b0;
  logic        rst_s    = 1'b1;
  rf_wr_t      last_wr;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, predict grants from the rules, check readies.
  task automatic drive_cycle(input logic rst,
                             input logic v0, input logic [4:0] i0, input logic [31:0] d0,
                             input logic v1, input logic [4:0] i1, input logic [31:0] d1,
                             output logic g0, output logic g1, output logic a1);
    logic e0, e1;
    @(posedge clk);
    #1;
    reset          = rst;
    bus.s0_valid_i = v0;
    bus.s0_idx_i   = i0;
    bus.s0_data_i  = d0;
    bus.s1_valid_i = v1;
    bus.s1_idx_i   = i1;
    bus.s1_data_i  = d1;
    @(negedge clk);
    if (rst) begin
      e0 = 1'b0;
      e1 = 1'b0;
    end else begin
      e1 = v1 && (!v0 || wait1 >= STARVE_MAX);
      e0 = v0 && !e1;
    end
    check_val("s0_ready", 32'(bus.s0_ready_o), 32'(e0));
    check_val("s1_ready", 32'(bus.s1_ready_o), 32'(e1));
    if (e0 && i0 != 5'd0) exp_q.push_back('{idx: i0, data: d0});
    if (e1 && i1 != 5'd0) exp_q.push_back('{idx: i1, data: d1});
    if (rst || !v1 || e1) wait1 = 0;
    else                  wait1++;
`ifdef RF_ARB_STAT_EN
    check_val("conflict_cnt", conflict_cnt, 32'(conflict_model));
    if (rst)           conflict_model = 0;
    else if (v0 && v1) conflict_model++;
`endif
    g0 = e0;
    g1 = e1;
    a1 = bus.s1_ready_o;
  endtask

  always @(posedge clk) rst_s = reset;

  // Monitor: compares every enabled write against the queue, idle cycles against hold.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_s) begin
        checks++;
        if (bus.rd_wen_o !== 1'b0 || bus.rd_idx_o !== 5'd0 || bus.rd_wdata_o !== 32'd0) begin
          failures++;
          $display("FAIL reset_out actual wen=%b idx=%0d data=0x%08h expected 0/0/0",
                   bus.rd_wen_o, bus.rd_idx_o, bus.rd_wdata_o);
        end
        last_wr = '0;
      end else if (bus.rd_wen_o === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL spurious_wen actual idx=%0d data=0x%08h expected no write",
                   bus.rd_idx_o, bus.rd_wdata_o);
        end else begin
          rf_wr_t e;
          e = exp_q.pop_front();
          if (bus.rd_idx_o !== e.idx || bus.rd_wdata_o !== e.data) begin
            failures++;
            $display("FAIL write actual idx=%0d data=0x%08h expected idx=%0d data=0x%08h",
                     bus.rd_idx_o, bus.rd_wdata_o, e.idx, e.data);
          end
        end
        last_wr.idx  = bus.rd_idx_o;
        last_wr.data = bus.rd_wdata_o;
        shadow_rf[bus.rd_idx_o] = bus.rd_wdata_o;
      end else begin
        checks++;
        if (bus.rd_wen_o !== 1'b0 || bus.rd_idx_o !== last_wr.idx || bus.rd_wdata_o !== last_wr.data) begin
          failures++;
          $display("FAIL idle_hold actual wen=%b idx=%0d data=0x%08h expected wen=0 idx=%0d data=0x%08h",
                   bus.rd_wen_o, bus.rd_idx_o, bus.rd_wdata_o, last_wr.idx, last_wr.data);
        end
      end
    end
  end

  initial begin
    logic        g0, g1, a1;
    logic        p0, p1;
    logic [4:0]  i0, i1;
    logic [31:0] d0, d1;
    int          first_s1;

    for (int r = 0; r < 32; r++) shadow_rf[r] = 32'd0;
    last_wr = '0;
    bus.s0_valid_i = 1'b0; bus.s0_idx_i = '0; bus.s0_data_i = '0;
    bus.s1_valid_i = 1'b0; bus.s1_idx_i = '0; bus.s1_data_i = '0;

    // Reset with both sources requesting: no readies.
    drive_cycle(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, g0, g1, a1);
    mon_en = 1'b1;
    drive_cycle(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, g0, g1, a1);

    // Single src0 write, visible the next cycle.
    drive_cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, g0, g1, a1);
    drive_cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, g0, g1, a1);
    check_val("single_wen",  32'(bus.rd_wen_o), 32'd1);
    check_val("single_idx",  32'(bus.rd_idx_o), 32'd5);
    check_val("single_data", bus.rd_wdata_o, 32'hDEADBEEF);

    // Same index from both sources: src0 first, src1 last.
    drive_cycle(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, g0, g1, a1);
    drive_cycle(1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 32'h22, g0, g1, a1);
    drive_cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, g0, g1, a1);
    drive_cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, g0, g1, a1);
    check_val("x3_final", shadow_rf[3], 32'h22);

    // x0 destination: accepted, never written.
    drive_cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF, g0, g1, a1);
    check_val("x0_ready", 32'(a1), 32'd1);
    drive_cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, g0, g1, a1);
    check_val("x0_no_wen", 32'(bus.rd_wen_o), 32'd0);

    // Starvation guard: src1 must get through in its 9th cycle of waiting.
    p1 = 1'b1;
    first_s1 = -1;
    for (int c = 0; c < 12; c++) begin
      drive_cycle(1'b0, 1'b1, 5'(1 + c % 30), 32'h5000_0000 + 32'(c),
                  p1, 5'd7, 32'hCAFE0007, g0, g1, a1);
      if (a1 && first_s1 < 0) first_s1 = c;
      if (g1) p1 = 1'b0;
    end
    check_val("starve_grant_cycle", 32'(first_s1), 32'd8);

    // Reset mid-wait, then src0 must win first after release.
    for (int c = 0; c < 5; c++)
      drive_cycle(1'b0, 1'b1, 5'(10 + c), 32'h6000_0000 + 32'(c), 1'b1, 5'd9, 32'h99, g0, g1, a1);
    drive_cycle(1'b1, 1'b1, 5'd20, 32'h77, 1'b1, 5'd9, 32'h99, g0, g1, a1);
    drive_cycle(1'b0, 1'b1, 5'd20, 32'h77, 1'b1, 5'd9, 32'h99, g0, g1, a1);
    check_val("post_reset_s0_first", 32'(a1), 32'd0);
    drive_cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, g0, g1, a1);
    drive_cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, g0, g1, a1);

    // Randomized traffic with held requests and occasional resets.
    p0 = 1'b0; p1 = 1'b0;
    i0 = '0; i1 = '0; d0 = '0; d1 = '0;
    for (int c = 0; c < 1500; c++) begin
      if (!p0 && ($urandom % 3) != 0) begin
        p0 = 1'b1; i0 = 5'($urandom % 32); d0 = $urandom;
      end
      if (!p1 && ($urandom % 4) != 0) begin
        p1 = 1'b1; i1 = 5'($urandom % 32); d1 = $urandom;
      end
      drive_cycle(($urandom % 50) == 0, p0, i0, d0, p1, i1, d1, g0, g1, a1);
      if (g0) p0 = 1'b0;
      if (g1) p1 = 1'b0;
    end

    for (int c = 0; c < 3; c++)
      drive_cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, g0, g1, a1);
    check_val("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
